// File: rtl/ssd_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ssd_scan_decoder                                             |
// | Description : Receive side of the 4-digit scan-multiplexed seven-segment   |
// |               display. Captures each settled digit, rebuilds the counter   |
// |               value (0..15) and the direction arrow, and publishes them    |
// |               once a frame has been seen STABLE_FRAMES times in a row.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ssd_scan_decoder #(
  parameter int SETTLE        = 4,
  parameter int STABLE_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg_in,
  input  logic [3:0] an_in,
  output logic [3:0] value,
  output logic       dir,
  output logic       value_valid,
  output logic       frame_pulse,
  output logic       err
);

  // Active-low glyph bytes: bit7..bit1 = a..g, bit0 = dp
  localparam logic [7:0] c_g0    = 8'b0000_0011;
  localparam logic [7:0] c_g1    = 8'b1001_1111;
  localparam logic [7:0] c_g2    = 8'b0010_0101;
  localparam logic [7:0] c_g3    = 8'b0000_1101;
  localparam logic [7:0] c_g4    = 8'b1001_1001;
  localparam logic [7:0] c_g5    = 8'b0100_1001;
  localparam logic [7:0] c_g6    = 8'b0100_0001;
  localparam logic [7:0] c_g7    = 8'b0001_1111;
  localparam logic [7:0] c_g8    = 8'b0000_0001;
  localparam logic [7:0] c_g9    = 8'b0000_1001;
  localparam logic [7:0] c_up    = 8'b0011_1011;
  localparam logic [7:0] c_down  = 8'b1100_0111;
  localparam logic [8:0] c_settle = 9'(SETTLE);
  localparam logic [3:0] c_stable = 4'(STABLE_FRAMES);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [7:0]      r_seg;
  logic [3:0]      r_an;
  logic [7:0]      r_cnt;
  logic [1:0]      r_cur;
  logic [3:0]      r_seen;
  logic [3:0][7:0] r_slots;
  logic [3:0][7:0] r_fr;
  logic            r_eval;
  logic [3:0]      r_stab;
  logic [3:0]      r_last_val;
  logic            r_last_dir;
  logic [3:0]      r_value;
  logic            r_dir;
  logic            r_valid;
  logic            r_pulse;
  logic            r_err;

  logic            w_valid;
  logic            w_illegal;
  logic [1:0]      w_slot;
  logic            w_same;
  logic [8:0]      w_cnt_inc;
  logic            w_load;
  logic            w_incr;
  logic            w_capture;
  logic            w_wrap;
  logic            w_t_ok;
  logic            w_o_ok;
  logic            w_a1_ok;
  logic            w_a0_ok;
  logic            w_a1_up;
  logic            w_a0_up;
  logic            w_tens;
  logic [3:0]      w_ones;
  logic [4:0]      w_sum;
  logic            w_frame_err;
  logic            w_do_eval;
  logic            w_good;
  logic            w_match;
  logic [3:0]      w_stab_next;
  logic            w_update;

  // Single register stage on the scanner lines; everything downstream uses these
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg <= 8'hFF;
      r_an  <= 4'hF;
    end else begin
      r_seg <= seg_in;
      r_an  <= an_in;
    end
  end

  // Anode classification: one-hot-low selects a slot, all-high is blank, rest illegal
  always_comb begin
    w_valid   = 1'b0;
    w_illegal = 1'b0;
    w_slot    = 2'd0;
    case (r_an)
      4'b0111: begin w_valid = 1'b1; w_slot = 2'd3; end
      4'b1011: begin w_valid = 1'b1; w_slot = 2'd2; end
      4'b1101: begin w_valid = 1'b1; w_slot = 2'd1; end
      4'b1110: begin w_valid = 1'b1; w_slot = 2'd0; end
      4'b1111: w_illegal = 1'b0;
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_same    = w_valid && (w_slot == r_cur);
  assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_WAIT;
    else        r_state <= w_state_next;
  end

  // FSM next state and datapath controls
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_incr       = 1'b0;
    w_capture    = 1'b0;
    if (w_illegal) begin
      w_state_next = S_WAIT;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (w_valid) begin
            w_load       = 1'b1;
            w_state_next = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (w_same) begin
            if (w_cnt_inc >= c_settle) begin
              w_capture    = 1'b1;
              w_state_next = S_HOLD;
            end else begin
              w_incr = 1'b1;
            end
          end else if (w_valid) begin
            // anode moved before settling: restart on the new slot
            w_load = 1'b1;
          end else begin
            w_state_next = S_WAIT;
          end
        end
        S_HOLD: begin
          if (w_valid && !w_same) begin
            w_load       = 1'b1;
            w_state_next = S_SETTLE;
          end
        end
        default: w_state_next = S_WAIT;
      endcase
    end
  end

  // Settle counter and the slot currently being settled or held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
      r_cur <= 2'd0;
    end else if (w_load) begin
      r_cnt <= 8'd1;
      r_cur <= w_slot;
    end else if (w_incr) begin
      r_cnt <= w_cnt_inc[7:0];
    end
  end

  // A slot-3 capture on a full mask closes the previous frame and opens the next
  assign w_wrap = w_capture && (r_cur == 2'd3) && (r_seen == 4'b1111);

  // Slot captures, seen mask and the frame snapshot handed to evaluation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_slots <= '0;
      r_fr    <= '0;
      r_seen  <= 4'b0000;
      r_eval  <= 1'b0;
    end else begin
      r_eval <= w_wrap;
      if (w_illegal) begin
        r_seen <= 4'b0000;
      end else if (w_capture) begin
        r_slots[r_cur] <= r_seg;
        if (w_wrap) begin
          r_fr   <= r_slots;
          r_seen <= 4'b1000;
        end else begin
          r_seen <= r_seen | (4'b0001 << r_cur);
        end
      end
    end
  end

  // Glyph decode of the frozen frame
  always_comb begin
    w_t_ok  = 1'b1;
    w_tens  = 1'b0;
    w_o_ok  = 1'b1;
    w_ones  = 4'd0;
    w_a1_ok = 1'b1;
    w_a1_up = 1'b0;
    w_a0_ok = 1'b1;
    w_a0_up = 1'b0;
    case (r_fr[3])
      c_g0:    w_tens = 1'b0;
      c_g1:    w_tens = 1'b1;
      default: w_t_ok = 1'b0;
    endcase
    case (r_fr[2])
      c_g0:    w_ones = 4'd0;
      c_g1:    w_ones = 4'd1;
      c_g2:    w_ones = 4'd2;
      c_g3:    w_ones = 4'd3;
      c_g4:    w_ones = 4'd4;
      c_g5:    w_ones = 4'd5;
      c_g6:    w_ones = 4'd6;
      c_g7:    w_ones = 4'd7;
      c_g8:    w_ones = 4'd8;
      c_g9:    w_ones = 4'd9;
      default: w_o_ok = 1'b0;
    endcase
    case (r_fr[1])
      c_up:    w_a1_up = 1'b1;
      c_down:  w_a1_up = 1'b0;
      default: w_a1_ok = 1'b0;
    endcase
    case (r_fr[0])
      c_up:    w_a0_up = 1'b1;
      c_down:  w_a0_up = 1'b0;
      default: w_a0_ok = 1'b0;
    endcase
  end

  assign w_sum       = (w_tens ? 5'd10 : 5'd0) + {1'b0, w_ones};
  assign w_frame_err = !(w_t_ok && w_o_ok && w_a1_ok && w_a0_ok) ||
                       (w_a1_up != w_a0_up) || (w_sum > 5'd15);
  // an illegal anode in the same cycle suppresses evaluation entirely
  assign w_do_eval   = r_eval && !w_illegal;
  assign w_good      = w_do_eval && !w_frame_err;
  assign w_match     = (w_sum[3:0] == r_last_val) && (w_a1_up == r_last_dir);
  assign w_stab_next = !w_match ? 4'd1 : ((r_stab == 4'd15) ? 4'd15 : r_stab + 4'd1);
  assign w_update    = w_good && (w_stab_next >= c_stable) &&
                       (!r_valid || (w_sum[3:0] != r_value) || (w_a1_up != r_dir));

  // Stability filter, published outputs and event pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stab     <= 4'd0;
      r_last_val <= 4'd0;
      r_last_dir <= 1'b1;
      r_value    <= 4'd0;
      r_dir      <= 1'b1;
      r_valid    <= 1'b0;
      r_pulse    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err   <= w_illegal || (w_do_eval && w_frame_err);
      r_pulse <= w_update;
      if (w_do_eval) begin
        if (w_frame_err) begin
          r_stab <= 4'd0;
        end else begin
          r_stab     <= w_stab_next;
          r_last_val <= w_sum[3:0];
          r_last_dir <= w_a1_up;
        end
      end
      if (w_update) begin
        r_value <= w_sum[3:0];
        r_dir   <= w_a1_up;
        r_valid <= 1'b1;
      end
    end
  end

  assign value       = r_value;
  assign dir         = r_dir;
  assign value_valid = r_valid;
  assign frame_pulse = r_pulse;
  assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ssd_scan_decoder                                          |
// | Description : Directed self-checking bench for ssd_scan_decoder.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ssd_scan_decoder;

  localparam logic [7:0] c_g0   = 8'b0000_0011;
  localparam logic [7:0] c_g1   = 8'b1001_1111;
  localparam logic [7:0] c_g2   = 8'b0010_0101;
  localparam logic [7:0] c_g3   = 8'b0000_1101;
  localparam logic [7:0] c_g4   = 8'b1001_1001;
  localparam logic [7:0] c_g5   = 8'b0100_1001;
  localparam logic [7:0] c_g7   = 8'b0001_1111;
  localparam logic [7:0] c_g9   = 8'b0000_1001;
  localparam logic [7:0] c_up   = 8'b0011_1011;
  localparam logic [7:0] c_down = 8'b1100_0111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] seg_in = 8'hFF;
  logic [3:0] an_in = 4'hF;
  logic [3:0] value;
  logic       dir;
  logic       value_valid;
  logic       frame_pulse;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pulse = 0;
  int n_err = 0;

  ssd_scan_decoder #(.SETTLE(4), .STABLE_FRAMES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .value       (value),
    .dir         (dir),
    .value_valid (value_valid),
    .frame_pulse (frame_pulse),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Count output pulses away from the active edge
  always @(negedge clk) begin
    if (frame_pulse === 1'b1) n_pulse++;
    if (err === 1'b1) n_err++;
  end

  task automatic do_reset();
    an_in  = 4'hF;
    seg_in = 8'hFF;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic digit(input logic [3:0] a, input logic [7:0] s, input int dwell);
    an_in  = a;
    seg_in = s;
    repeat (dwell) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] t, input logic [7:0] o, input logic [7:0] ar,
                       input int dwell, input int gap);
    digit(4'b0111, t, dwell);
    if (gap > 0) digit(4'b1111, 8'hFF, gap);
    digit(4'b1011, o, dwell);
    if (gap > 0) digit(4'b1111, 8'hFF, gap);
    digit(4'b1101, ar, dwell);
    if (gap > 0) digit(4'b1111, 8'hFF, gap);
    digit(4'b1110, ar, dwell);
    if (gap > 0) digit(4'b1111, 8'hFF, gap);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (value !== 4'd0) begin n_bad++; $display("FAIL reset_value: got %0d want 0", value); end
    n_cmp++; if (dir !== 1'b1) begin n_bad++; $display("FAIL reset_dir: got %0b want 1", dir); end
    n_cmp++; if (value_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", value_valid); end
    n_cmp++; if (frame_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulse: got %0b want 0", frame_pulse); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b want 0", err); end
  endtask

  task automatic test_basic_15_up();
    int p0, e0;
    do_reset();
    p0 = n_pulse; e0 = n_err;
    repeat (2) frame(c_g1, c_g5, c_up, 8, 0);
    n_cmp++; if (n_pulse !== p0) begin n_bad++; $display("FAIL basic_early_pulse: got %0d want %0d", n_pulse, p0); end
    n_cmp++; if (value_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid: got %0b want 0", value_valid); end
    frame(c_g1, c_g5, c_up, 8, 0);
    n_cmp++; if (n_pulse !== p0 + 1) begin n_bad++; $display("FAIL basic_pulse: got %0d want %0d", n_pulse, p0 + 1); end
    n_cmp++; if (value !== 4'd15) begin n_bad++; $display("FAIL basic_value: got %0d want 15", value); end
    n_cmp++; if (dir !== 1'b1) begin n_bad++; $display("FAIL basic_dir: got %0b want 1", dir); end
    n_cmp++; if (value_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %0b want 1", value_valid); end
    frame(c_g1, c_g5, c_up, 8, 0);
    n_cmp++; if (n_pulse !== p0 + 1) begin n_bad++; $display("FAIL basic_no_repeat_pulse: got %0d want %0d", n_pulse, p0 + 1); end
    n_cmp++; if (n_err !== e0) begin n_bad++; $display("FAIL basic_err: got %0d want %0d", n_err, e0); end
  endtask

  task automatic test_change_03_to_04();
    int p0;
    do_reset();
    p0 = n_pulse;
    repeat (3) frame(c_g0, c_g3, c_down, 8, 0);
    n_cmp++; if (value !== 4'd3) begin n_bad++; $display("FAIL chg_value3: got %0d want 3", value); end
    n_cmp++; if (dir !== 1'b0) begin n_bad++; $display("FAIL chg_dir: got %0b want 0", dir); end
    repeat (2) frame(c_g0, c_g4, c_down, 8, 0);
    n_cmp++; if (value !== 4'd3) begin n_bad++; $display("FAIL chg_held3: got %0d want 3", value); end
    n_cmp++; if (n_pulse !== p0 + 1) begin n_bad++; $display("FAIL chg_pulse_one: got %0d want %0d", n_pulse, p0 + 1); end
    frame(c_g0, c_g4, c_down, 8, 0);
    n_cmp++; if (value !== 4'd4) begin n_bad++; $display("FAIL chg_value4: got %0d want 4", value); end
    n_cmp++; if (n_pulse !== p0 + 2) begin n_bad++; $display("FAIL chg_pulse_two: got %0d want %0d", n_pulse, p0 + 2); end
  endtask

  task automatic test_overrange_17();
    int p0, e0;
    do_reset();
    p0 = n_pulse; e0 = n_err;
    repeat (3) frame(c_g1, c_g7, c_up, 8, 0);
    n_cmp++; if (n_err !== e0 + 2) begin n_bad++; $display("FAIL ovr_err_count: got %0d want %0d", n_err, e0 + 2); end
    n_cmp++; if (value_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_valid: got %0b want 0", value_valid); end
    n_cmp++; if (value !== 4'd0) begin n_bad++; $display("FAIL ovr_value: got %0d want 0", value); end
    n_cmp++; if (n_pulse !== p0) begin n_bad++; $display("FAIL ovr_pulse: got %0d want %0d", n_pulse, p0); end
  endtask

  task automatic test_illegal_anode();
    int p0, e0;
    do_reset();
    p0 = n_pulse; e0 = n_err;
    digit(4'b0111, c_g1, 8);
    digit(4'b1011, c_g5, 8);
    digit(4'b1101, c_up, 8);
    digit(4'b1001, c_g0, 1);
    repeat (3) frame(c_g1, c_g5, c_up, 8, 0);
    n_cmp++; if (n_err !== e0 + 1) begin n_bad++; $display("FAIL ill_err_count: got %0d want %0d", n_err, e0 + 1); end
    n_cmp++; if (n_pulse !== p0 + 1) begin n_bad++; $display("FAIL ill_pulse: got %0d want %0d", n_pulse, p0 + 1); end
    n_cmp++; if (value !== 4'd15) begin n_bad++; $display("FAIL ill_value: got %0d want 15", value); end
    n_cmp++; if (value_valid !== 1'b1) begin n_bad++; $display("FAIL ill_valid: got %0b want 1", value_valid); end
  endtask

  task automatic test_short_dwell_and_blanks();
    int p0, e0;
    do_reset();
    p0 = n_pulse; e0 = n_err;
    repeat (4) frame(c_g1, c_g5, c_up, 3, 0);
    n_cmp++; if (n_pulse !== p0) begin n_bad++; $display("FAIL short_pulse: got %0d want %0d", n_pulse, p0); end
    n_cmp++; if (n_err !== e0) begin n_bad++; $display("FAIL short_err: got %0d want %0d", n_err, e0); end
    n_cmp++; if (value_valid !== 1'b0) begin n_bad++; $display("FAIL short_valid: got %0b want 0", value_valid); end
    repeat (3) frame(c_g1, c_g2, c_down, 8, 2);
    n_cmp++; if (value !== 4'd12) begin n_bad++; $display("FAIL blank_value: got %0d want 12", value); end
    n_cmp++; if (dir !== 1'b0) begin n_bad++; $display("FAIL blank_dir: got %0b want 0", dir); end
    n_cmp++; if (n_pulse !== p0 + 1) begin n_bad++; $display("FAIL blank_pulse: got %0d want %0d", n_pulse, p0 + 1); end
    n_cmp++; if (n_err !== e0) begin n_bad++; $display("FAIL blank_err: got %0d want %0d", n_err, e0); end
  endtask

  task automatic test_reset_mid_frame();
    int p0;
    do_reset();
    repeat (3) frame(c_g1, c_g5, c_up, 8, 0);
    n_cmp++; if (value !== 4'd15) begin n_bad++; $display("FAIL rmid_pre_value: got %0d want 15", value); end
    digit(4'b0111, c_g1, 8);
    digit(4'b1011, c_g5, 8);
    digit(4'b1101, c_up, 4);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if (value !== 4'd0) begin n_bad++; $display("FAIL rmid_value: got %0d want 0", value); end
    n_cmp++; if (dir !== 1'b1) begin n_bad++; $display("FAIL rmid_dir: got %0b want 1", dir); end
    n_cmp++; if (value_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %0b want 0", value_valid); end
    p0 = n_pulse;
    digit(4'b1101, c_up, 4);
    digit(4'b1110, c_up, 8);
    repeat (3) frame(c_g0, c_g9, c_up, 8, 0);
    n_cmp++; if (value !== 4'd9) begin n_bad++; $display("FAIL rmid_rec_value: got %0d want 9", value); end
    n_cmp++; if (dir !== 1'b1) begin n_bad++; $display("FAIL rmid_rec_dir: got %0b want 1", dir); end
    n_cmp++; if (value_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_rec_valid: got %0b want 1", value_valid); end
    n_cmp++; if (n_pulse !== p0 + 1) begin n_bad++; $display("FAIL rmid_rec_pulse: got %0d want %0d", n_pulse, p0 + 1); end
  endtask

  initial begin
    test_reset();
    test_basic_15_up();
    test_change_03_to_04();
    test_overrange_17();
    test_illegal_anode();
    test_short_dwell_and_blanks();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
